// File: rtl/mul_pkg.sv
// Shared types and defaults for the iterative unsigned multiplier.
// No logic here; consumed by the interface, step and top modules.
// No handshake of its own.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    localparam int MUL_WIDTH_DEFAULT = 32;

endpackage

// File: rtl/multiplier_unsigned_seq_if.sv
// Operand/result handshake bundle for the multiplier.
// No latency; plain wires.
// master drives operands and result-ready; slave is the multiplier unit.
interface multiplier_unsigned_seq_if
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH_DEFAULT
);
    logic                 i_in_valid;
    logic                 o_in_ready;
    logic [WIDTH-1:0]     i_multiplicand;
    logic [WIDTH-1:0]     i_multiplier;
    logic                 o_out_valid;
    logic                 i_out_ready;
    logic [2*WIDTH-1:0]   o_product;

    modport master (
        output i_in_valid, i_multiplicand, i_multiplier, i_out_ready,
        input  o_in_ready, o_out_valid, o_product
    );

    modport slave (
        input  i_in_valid, i_multiplicand, i_multiplier, i_out_ready,
        output o_in_ready, o_out_valid, o_product
    );
endinterface

// File: rtl/mulu_1iter.sv
// One shift-and-add step: conditionally add multiplicand, shift both operands.
// Latency: purely combinational.
// No handshake; the caller decides when to register the result.
module mulu_1iter
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH_DEFAULT
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [2*WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0]   mplier,
    output logic [2*WIDTH-1:0] acc_next,
    output logic [2*WIDTH-1:0] mcand_next,
    output logic [WIDTH-1:0]   mplier_next
);

    // Add the shifted multiplicand when the current multiplier LSB is set;
    // the 2*WIDTH accumulator cannot overflow for a WIDTH x WIDTH product.
    always_comb begin
        acc_next    = mplier[0] ? (acc + mcand) : acc;
        mcand_next  = mcand << 1;
        mplier_next = mplier >> 1;
    end

endmodule

// File: rtl/multiplier_unsigned_seq.sv
// Iterative unsigned shift-and-add multiplier, one multiplier bit per cycle.
// Latency: fixed WIDTH cycles from accept edge to o_out_valid; no early exit.
// Result held in DONE until i_out_ready; inputs refused outside IDLE.
module multiplier_unsigned_seq
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst,
    multiplier_unsigned_seq_if.slave    bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    mul_state_t           state, state_nxt;
    logic [CW-1:0]        count, count_nxt;
    logic [2*WIDTH-1:0]   acc, acc_nxt;
    logic [2*WIDTH-1:0]   mcand, mcand_nxt;
    logic [WIDTH-1:0]     mplier, mplier_nxt;
    logic                 in_ready;
    logic                 out_valid;

    logic [2*WIDTH-1:0]   step_acc;
    logic [2*WIDTH-1:0]   step_mcand;
    logic [WIDTH-1:0]     step_mplier;

    mulu_1iter #(.WIDTH(WIDTH)) u_step (
        .acc         (acc),
        .mcand       (mcand),
        .mplier      (mplier),
        .acc_next    (step_acc),
        .mcand_next  (step_mcand),
        .mplier_next (step_mplier)
    );

    // Next-state, datapath updates and handshake outputs.
    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        acc_nxt    = acc;
        mcand_nxt  = mcand;
        mplier_nxt = mplier;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.i_in_valid) begin
                    mcand_nxt  = {{WIDTH{1'b0}}, bus.i_multiplicand};
                    mplier_nxt = bus.i_multiplier;
                    acc_nxt    = '0;
                    count_nxt  = '0;
                    state_nxt  = BUSY;
                end
            end
            BUSY: begin
                acc_nxt    = step_acc;
                mcand_nxt  = step_mcand;
                mplier_nxt = step_mplier;
                // Final iteration parks count at WIDTH-1 rather than wrapping.
                if (count == LAST) begin
                    state_nxt = DONE;
                end else begin
                    count_nxt = count + 1'b1;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (bus.i_out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            count  <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else begin
            state  <= state_nxt;
            count  <= count_nxt;
            acc    <= acc_nxt;
            mcand  <= mcand_nxt;
            mplier <= mplier_nxt;
        end
    end

    assign bus.o_in_ready  = in_ready;
    assign bus.o_out_valid = out_valid;
    assign bus.o_product   = acc;

endmodule

// File: tb/tb_multiplier_unsigned_seq.sv
// Directed bench for the iterative unsigned multiplier.
// Drives operands #1 after each rising edge and samples at the same point.
// Result back-pressure exercised explicitly in one step.
module tb_multiplier_unsigned_seq;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;
    int   lat;

    multiplier_unsigned_seq_if #(.WIDTH(32)) bus ();

    multiplier_unsigned_seq #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present operands for exactly one edge while the unit is idle.
    task automatic accept(input logic [31:0] a, input logic [31:0] b);
        bus.i_in_valid     = 1'b1;
        bus.i_multiplicand = a;
        bus.i_multiplier   = b;
        tick();
        bus.i_in_valid     = 1'b0;
    endtask

    // Count edges until o_out_valid, bounded so a dead unit cannot hang the run.
    task automatic wait_done(output int n);
        n = 0;
        while (bus.o_out_valid !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
    endtask

    initial begin
        rst                = 1'b1;
        bus.i_in_valid     = 1'b0;
        bus.i_multiplicand = '0;
        bus.i_multiplier   = '0;
        bus.i_out_ready    = 1'b1;

        // 1. reset then 3*5
        tick();
        rst = 1'b0;
        check("rst_in_ready", 64'(bus.o_in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.o_out_valid), 64'd0);
        check("rst_product", bus.o_product, 64'd0);
        accept(32'd3, 32'd5);
        check("busy_in_ready", 64'(bus.o_in_ready), 64'd0);
        wait_done(lat);
        check("lat_3x5", 64'(lat), 64'd32);
        check("prod_3x5", bus.o_product, 64'h0F);
        tick();
        check("retire_out_valid", 64'(bus.o_out_valid), 64'd0);
        check("retire_in_ready", 64'(bus.o_in_ready), 64'd1);

        // 2. maximum operands
        accept(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(lat);
        check("lat_max", 64'(lat), 64'd32);
        check("prod_max", bus.o_product, 64'hFFFF_FFFE_0000_0001);
        tick();

        // 3. zero and identity
        accept(32'd0, 32'h1234_5678);
        wait_done(lat);
        check("lat_zero", 64'(lat), 64'd32);
        check("prod_zero", bus.o_product, 64'd0);
        tick();
        accept(32'hDEAD_BEEF, 32'd1);
        wait_done(lat);
        check("lat_ident", 64'(lat), 64'd32);
        check("prod_ident", bus.o_product, 64'h0000_0000_DEAD_BEEF);
        tick();

        // 4. back-pressure with new operands offered during DONE
        bus.i_out_ready = 1'b0;
        accept(32'd6, 32'd7);
        wait_done(lat);
        check("lat_bp", 64'(lat), 64'd32);
        bus.i_in_valid     = 1'b1;
        bus.i_multiplicand = 32'd99;
        bus.i_multiplier   = 32'd99;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_product", bus.o_product, 64'd42);
            check("bp_out_valid", 64'(bus.o_out_valid), 64'd1);
            check("bp_in_ready", 64'(bus.o_in_ready), 64'd0);
        end
        bus.i_out_ready = 1'b1;
        tick();
        check("bp_retire_out_valid", 64'(bus.o_out_valid), 64'd0);
        check("bp_retire_in_ready", 64'(bus.o_in_ready), 64'd1);
        bus.i_in_valid = 1'b0;

        // 5. reset in the middle of an operation
        accept(32'd1000, 32'd1000);
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_out_valid", 64'(bus.o_out_valid), 64'd0);
        check("midrst_in_ready", 64'(bus.o_in_ready), 64'd1);
        check("midrst_product", bus.o_product, 64'd0);
        accept(32'd7, 32'd6);
        wait_done(lat);
        check("lat_7x6", 64'(lat), 64'd32);
        check("prod_7x6", bus.o_product, 64'd42);
        tick();

        // 6. back-to-back with valid and ready held high
        bus.i_in_valid     = 1'b1;
        bus.i_multiplicand = 32'd2;
        bus.i_multiplier   = 32'd3;
        tick();
        bus.i_multiplicand = 32'd65536;
        bus.i_multiplier   = 32'd65536;
        wait_done(lat);
        check("lat_b2b_1", 64'(lat), 64'd32);
        check("prod_b2b_1", bus.o_product, 64'd6);
        tick();
        check("b2b_gap_in_ready", 64'(bus.o_in_ready), 64'd1);
        check("b2b_gap_out_valid", 64'(bus.o_out_valid), 64'd0);
        tick();
        check("b2b_accept2_in_ready", 64'(bus.o_in_ready), 64'd0);
        bus.i_in_valid = 1'b0;
        wait_done(lat);
        check("lat_b2b_2", 64'(lat), 64'd32);
        check("prod_b2b_2", bus.o_product, 64'h1_0000_0000);
        tick();
        check("b2b_final_out_valid", 64'(bus.o_out_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
